bcd_score_counter: RTL and testbench

- Parametrised N-digit BCD score counter driven by a raw push-button, replacing the fixed 3-digit binary counter with modulo division used in the VGA game top level.
- Synchronises, debounces and edge-detects the button. Supports auto-repeat while the button is held, up/down counting, wrap or saturate mode, synchronous clear and parallel load.
- Feeds the per-digit display renderers directly. Outputs packed BCD digits plus a leading-zero blank mask, so no divide/modulo logic is needed.

---
 rtl/bcd_score_counter.sv | 246 ++++++++++++++++++++++++
 tb/tb_bcd_score_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// N-digit BCD score counter stepped by a debounced push-button, with auto-repeat,
// up/down counting, wrap or saturate at the limits, clear, load and leading-zero blanking.
module bcd_score_counter #(
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter int WRAP            = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  nPBTON,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  step_o,
  output logic                  limit_o
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } stepState_e;

  logic                 sync1_q, sync2_q;
  logic                 accepted_q, accepted_d;
  logic [DBW-1:0]       dbCnt_q, dbCnt_d;
  logic                 armed_q, armed_d;
  logic                 acceptEvt, pressEvt, releaseEvt;

  stepState_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 stepReq;

  logic [4*DIGITS-1:0]  incVal, decVal, loadClamped;
  logic                 allNines, allZero;

  logic [4*DIGITS-1:0]  digits_q, digits_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic                 step_q, step_d;
  logic                 limit_q, limit_d;

  // Synchroniser is deliberately not reset so a button held through reset stays visible.
  always_ff @(posedge CLK) begin
    sync1_q <= ~nPBTON;
    sync2_q <= sync1_q;
  end

  assign acceptEvt  = (sync2_q != accepted_q) && (dbCnt_q == DB_LAST);
  assign pressEvt   = acceptEvt && sync2_q;
  assign releaseEvt = acceptEvt && !sync2_q;

  // armed stays low after reset until the button is seen released, so a held press never steps.
  always_comb begin
    accepted_d = accepted_q;
    dbCnt_d    = '0;
    armed_d    = armed_q | ~sync2_q;
    if (sync2_q != accepted_q) begin
      if (dbCnt_q == DB_LAST) begin
        accepted_d = sync2_q;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      accepted_q <= 1'b0;
      dbCnt_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      accepted_q <= accepted_d;
      dbCnt_q    <= dbCnt_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    stepReq = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pressEvt && armed_q) begin
          stepReq = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (releaseEvt) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          stepReq = 1'b1;
          state_d = REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPEAT: begin
        if (releaseEvt) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == REP_LAST) begin
          stepReq = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Single-cycle ripple; the final carry/borrow doubles as the all-9s / all-0s detect.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    incVal = '0;
    decVal = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = digits_q[4*i +: 4];
      if (carry && dig == 4'd9) begin
        incVal[4*i +: 4] = 4'd0;
      end else begin
        incVal[4*i +: 4] = carry ? dig + 4'd1 : dig;
        carry = 1'b0;
      end
      if (borrow && dig == 4'd0) begin
        decVal[4*i +: 4] = 4'd9;
      end else begin
        decVal[4*i +: 4] = borrow ? dig - 4'd1 : dig;
        borrow = 1'b0;
      end
    end
    allNines = carry;
    allZero  = borrow;
  end

  always_comb begin
    logic [3:0] ld;
    loadClamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ld = load_val[4*i +: 4];
      loadClamped[4*i +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    end
  end

  always_comb begin
    digits_d = digits_q;
    step_d   = 1'b0;
    limit_d  = 1'b0;
    if (clr) begin
      digits_d = '0;
    end else if (load) begin
      digits_d = loadClamped;
    end else if (stepReq) begin
      if (up) begin
        if (!allNines) begin
          digits_d = incVal;
          step_d   = 1'b1;
        end else begin
          limit_d = 1'b1;
          if (WRAP != 0) begin
            digits_d = '0;
            step_d   = 1'b1;
          end
        end
      end else begin
        if (!allZero) begin
          digits_d = decVal;
          step_d   = 1'b1;
        end else begin
          limit_d = 1'b1;
          if (WRAP != 0) begin
            digits_d = {DIGITS{4'd9}};
            step_d   = 1'b1;
          end
        end
      end
    end
  end

  // Blank mask is derived from the next count so it registers alongside the digits.
  always_comb begin
    logic higherZero;
    blank_d    = '0;
    higherZero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higherZero = higherZero && (digits_d[4*i +: 4] == 4'd0);
      blank_d[i] = higherZero;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      digits_q   <= '0;
      blank_q    <= '1;
      blank_q[0] <= 1'b0;
      step_q     <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      blank_q  <= blank_d;
      step_q   <= step_d;
      limit_q  <= limit_d;
    end
  end

  assign digits  = digits_q;
  assign blank   = blank_q;
  assign step_o  = step_q;
  assign limit_o = limit_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: one wrapping and one saturating instance
// share all inputs; expected values are hand-computed per scenario.
module tb_bcd_score_counter;

  logic        CLK = 1'b0;
  logic        nRST, nPBTON, up, clr, load;
  logic [11:0] load_val;
  logic [11:0] digitsW, digitsS;
  logic [2:0]  blankW, blankS;
  logic        stepW, stepS, limitW, limitS;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stepCntW = 0, stepCntS = 0, limitCntW = 0, limitCntS = 0;
  int stepTimesW[$];

  bcd_score_counter #(.DIGITS(3), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
                      .REPEAT_CYCLES(5), .WRAP(1)) dutW (
    .CLK(CLK), .nRST(nRST), .nPBTON(nPBTON), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .digits(digitsW), .blank(blankW), .step_o(stepW), .limit_o(limitW));

  bcd_score_counter #(.DIGITS(3), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
                      .REPEAT_CYCLES(5), .WRAP(0)) dutS (
    .CLK(CLK), .nRST(nRST), .nPBTON(nPBTON), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .digits(digitsS), .blank(blankS), .step_o(stepS), .limit_o(limitS));

  always #5 CLK = ~CLK;

  // Pulse monitor samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    cyc++;
    if (stepW) begin
      stepCntW++;
      stepTimesW.push_back(cyc);
    end
    if (stepS)  stepCntS++;
    if (limitW) limitCntW++;
    if (limitS) limitCntS++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    nPBTON = level;
    tick(cycles);
  endtask

  task automatic doLoad(input logic [11:0] v);
    load_val = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic press();
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
  endtask

  task automatic test_reset();
    nRST = 1'b0; nPBTON = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    tick(3);
    checks++; if (digitsW !== 12'h000) begin failures++; $display("[TB] FAIL reset_digits: got %h expected %h", digitsW, 12'h000); end
    checks++; if (blankW !== 3'b110) begin failures++; $display("[TB] FAIL reset_blank: got %b expected %b", blankW, 3'b110); end
    checks++; if (stepW !== 1'b0 || limitW !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: got %b%b expected 00", stepW, limitW); end
    checks++; if (digitsS !== 12'h000) begin failures++; $display("[TB] FAIL reset_digits_sat: got %h expected %h", digitsS, 12'h000); end
    nRST = 1'b1;
    tick(3);
  endtask

  task automatic test_bounce();
    int base;
    base = stepCntW;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 2);
    end
    // A stable low is accepted exactly 6 edges later, with the step visible at that edge.
    applyStimulus(1'b0, 6);
    checks++; if (stepW !== 1'b1) begin failures++; $display("[TB] FAIL bounce_latency: got %b expected 1", stepW); end
    checks++; if (digitsW !== 12'h001) begin failures++; $display("[TB] FAIL bounce_digits: got %h expected %h", digitsW, 12'h001); end
    checks++; if (blankW !== 3'b110) begin failures++; $display("[TB] FAIL bounce_blank: got %b expected %b", blankW, 3'b110); end
    applyStimulus(1'b0, 1);
    checks++; if (stepW !== 1'b0) begin failures++; $display("[TB] FAIL bounce_pulse_width: got %b expected 0", stepW); end
    applyStimulus(1'b1, 10);
    checks++; if (stepCntW - base !== 1) begin failures++; $display("[TB] FAIL bounce_step_count: got %0d expected 1", stepCntW - base); end
  endtask

  task automatic test_autorepeat();
    int base;
    int gaps[6];
    gaps = '{20, 5, 5, 5, 5, 5};
    clr = 1'b1; tick(1); clr = 1'b0;
    up = 1'b1;
    base = stepCntW;
    stepTimesW.delete();
    // Release is accepted 48 edges after acceptance: after the +45 step, before +50.
    applyStimulus(1'b0, 48);
    applyStimulus(1'b1, 20);
    checks++; if (stepCntW - base !== 7) begin failures++; $display("[TB] FAIL repeat_step_count: got %0d expected 7", stepCntW - base); end
    checks++; if (digitsW !== 12'h007) begin failures++; $display("[TB] FAIL repeat_digits: got %h expected %h", digitsW, 12'h007); end
    for (int i = 0; i < 6 && i + 1 < stepTimesW.size(); i++) begin
      checks++;
      if (stepTimesW[i+1] - stepTimesW[i] !== gaps[i]) begin
        failures++;
        $display("[TB] FAIL repeat_gap%0d: got %0d expected %0d", i, stepTimesW[i+1] - stepTimesW[i], gaps[i]);
      end
    end
  endtask

  task automatic test_carry();
    doLoad(12'h099);
    checks++; if (blankW !== 3'b100) begin failures++; $display("[TB] FAIL load_blank: got %b expected %b", blankW, 3'b100); end
    up = 1'b1;
    press();
    checks++; if (digitsW !== 12'h100) begin failures++; $display("[TB] FAIL carry_up_digits: got %h expected %h", digitsW, 12'h100); end
    checks++; if (blankW !== 3'b000) begin failures++; $display("[TB] FAIL carry_up_blank: got %b expected %b", blankW, 3'b000); end
    up = 1'b0;
    press();
    checks++; if (digitsW !== 12'h099) begin failures++; $display("[TB] FAIL borrow_down_digits: got %h expected %h", digitsW, 12'h099); end
    checks++; if (blankW !== 3'b100) begin failures++; $display("[TB] FAIL borrow_down_blank: got %b expected %b", blankW, 3'b100); end
  endtask

  task automatic test_limits();
    int sW, sS, lW, lS;
    doLoad(12'h999);
    up = 1'b1;
    sW = stepCntW; sS = stepCntS; lW = limitCntW; lS = limitCntS;
    press();
    checks++; if (digitsW !== 12'h000) begin failures++; $display("[TB] FAIL wrap_up_digits: got %h expected %h", digitsW, 12'h000); end
    checks++; if (limitCntW - lW !== 1 || stepCntW - sW !== 1) begin failures++; $display("[TB] FAIL wrap_up_pulses: got limit %0d step %0d expected 1 1", limitCntW - lW, stepCntW - sW); end
    checks++; if (digitsS !== 12'h999) begin failures++; $display("[TB] FAIL sat_up_digits: got %h expected %h", digitsS, 12'h999); end
    checks++; if (limitCntS - lS !== 1 || stepCntS - sS !== 0) begin failures++; $display("[TB] FAIL sat_up_pulses: got limit %0d step %0d expected 1 0", limitCntS - lS, stepCntS - sS); end
    doLoad(12'h000);
    up = 1'b0;
    sS = stepCntS; lW = limitCntW; lS = limitCntS;
    press();
    checks++; if (digitsW !== 12'h999 || limitCntW - lW !== 1) begin failures++; $display("[TB] FAIL wrap_down: got %h limit %0d expected 999 1", digitsW, limitCntW - lW); end
    checks++; if (digitsS !== 12'h000) begin failures++; $display("[TB] FAIL sat_down_digits: got %h expected %h", digitsS, 12'h000); end
    checks++; if (limitCntS - lS !== 1 || stepCntS - sS !== 0) begin failures++; $display("[TB] FAIL sat_down_pulses: got limit %0d step %0d expected 1 0", limitCntS - lS, stepCntS - sS); end
  endtask

  task automatic test_priority();
    int base;
    doLoad(12'h321);
    up = 1'b1;
    base = stepCntW;
    // The step request is pending during the 6th cycle after the press; clr lands on it.
    applyStimulus(1'b0, 5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++; if (digitsW !== 12'h000) begin failures++; $display("[TB] FAIL clr_vs_step_digits: got %h expected %h", digitsW, 12'h000); end
    checks++; if (stepW !== 1'b0 || limitW !== 1'b0) begin failures++; $display("[TB] FAIL clr_vs_step_pulses: got %b%b expected 00", stepW, limitW); end
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 10);
    checks++; if (stepCntW - base !== 0 || digitsW !== 12'h000) begin failures++; $display("[TB] FAIL clr_vs_step_after: got %h steps %0d expected 000 0", digitsW, stepCntW - base); end
    doLoad(12'hA5C);
    checks++; if (digitsW !== 12'h959 || digitsS !== 12'h959) begin failures++; $display("[TB] FAIL load_clamp: got %h/%h expected %h", digitsW, digitsS, 12'h959); end
    checks++; if (blankW !== 3'b000) begin failures++; $display("[TB] FAIL load_clamp_blank: got %b expected %b", blankW, 3'b000); end
  endtask

  task automatic test_reset_mid();
    int base;
    doLoad(12'h040);
    up = 1'b1;
    // Steps at +6 and +26 after the press leave the FSM in REPEAT with 042.
    applyStimulus(1'b0, 28);
    checks++; if (digitsW !== 12'h042) begin failures++; $display("[TB] FAIL mid_setup_digits: got %h expected %h", digitsW, 12'h042); end
    nRST = 1'b0;
    tick(1);
    nRST = 1'b1;
    checks++; if (digitsW !== 12'h000 || blankW !== 3'b110) begin failures++; $display("[TB] FAIL mid_reset_state: got %h/%b expected 000/110", digitsW, blankW); end
    base = stepCntW;
    applyStimulus(1'b0, 40);
    checks++; if (stepCntW - base !== 0 || digitsW !== 12'h000) begin failures++; $display("[TB] FAIL mid_reset_held: got %h steps %0d expected 000 0", digitsW, stepCntW - base); end
    applyStimulus(1'b1, 10);
    press();
    checks++; if (stepCntW - base !== 1 || digitsW !== 12'h001) begin failures++; $display("[TB] FAIL mid_reset_repress: got %h steps %0d expected 001 1", digitsW, stepCntW - base); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_autorepeat();
    test_carry();
    test_limits();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
